text_scroller: RTL

- Upstream feeder for the 14-segment letter decoders.
- Buffers a message of 5-bit character codes loaded over a valid/ready write port.
- Scrolls the message right-to-left across a 4-digit window at a programmable step rate.
- Presents four registered 5-bit character codes, one per display digit, each driving one decoder instance.

---
 rtl/text_scroller.sv | 115 +++++++++++
 1 files changed

// File: rtl/text_scroller.sv
// Message buffer and right-to-left scroller feeding four 14-segment letter decoders.
// The message is shown through a 4-digit window over four leading blanks plus the message.
module text_scroller #(
  parameter int         DEPTH      = 16,
  parameter int         STEP_DIV   = 25000000,
  parameter logic [4:0] SPACE_CODE = 5'd27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  input  logic [4:0] wr_char,
  input  logic       wr_last,
  output logic       wr_ready,
  input  logic       pause,
  input  logic       stop,
  output logic       busy,
  output logic [4:0] digit3,
  output logic [4:0] digit2,
  output logic [4:0] digit1,
  output logic [4:0] digit0,
  output logic       wrap_pulse
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(DEPTH + 4) + 1;
  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [AW:0]        len;
  logic [PW-1:0]      pos;
  logic [PW-1:0]      vlen;
  logic [CW-1:0]      cnt;
  logic [4:0]         mem [DEPTH];
  logic [3:0][4:0]    win;
  logic [3:0][4:0]    digits;
  logic               tick;
  logic               wr_en;

  assign wr_ready = (state == IDLE);
  assign busy     = (state == RUN);
  assign vlen     = PW'(len) + PW'(4);
  assign tick     = busy && !pause && (cnt == CW'(STEP_DIV - 1));
  assign wr_en    = wr_ready && wr_valid && !stop;

  assign digit3 = digits[3];
  assign digit2 = digits[2];
  assign digit1 = digits[1];
  assign digit0 = digits[0];

  always_ff @(posedge clk)
    if (!rst && wr_en) mem[len[AW-1:0]] <= wr_char;

  // Window slot k shows stream index (pos+k) mod L; pos < L and k <= 3 < L, so one wrap suffices.
  always_comb begin
    logic [PW-1:0] idx;
    win = '0;
    for (int k = 0; k < 4; k++) begin
      idx = pos + PW'(k);
      if (idx >= vlen) idx = idx - vlen;
      if (idx < PW'(4)) win[3-k] = SPACE_CODE;
      else              win[3-k] = mem[AW'(idx - PW'(4))];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len        <= '0;
      pos        <= '0;
      cnt        <= '0;
      digits     <= {4{SPACE_CODE}};
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      digits     <= (state == RUN) ? win : {4{SPACE_CODE}};
      case (state)
        IDLE: begin
          if (stop) begin
            len <= '0;
          end else if (wr_valid) begin
            len <= len + 1'b1;
            // The DEPTH-th character is forced final so the buffer cannot overflow.
            if (wr_last || len == (AW+1)'(DEPTH - 1)) begin
              state <= RUN;
              pos   <= '0;
              cnt   <= '0;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            len   <= '0;
            pos   <= '0;
            cnt   <= '0;
          end else if (!pause) begin
            if (tick) begin
              cnt <= '0;
              if (pos == vlen - PW'(1)) begin
                pos        <= '0;
                wrap_pulse <= 1'b1;
              end else begin
                pos <= pos + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
